// File: rtl/line_buf_pkg.sv
// line_buf_pkg
// Shared types and defaults for the line-delay sequencer.
//   state_t      : sequencer state (IDLE / FILL / RUN)
//   *_DEF        : default address width, window height and line-counter width
//   HALF         : half window height for the default TAPS
//   half_taps()  : half window height for any TAPS value
package line_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 12;
  localparam int TAPS_DEF   = 5;
  localparam int LINE_W_DEF = 11;

  function automatic int half_taps(input int taps);
    return taps / 2;
  endfunction

  localparam int HALF = TAPS_DEF / 2;

endpackage

// File: rtl/vid_edge_det.sv
// vid_edge_det
// Registers DE and VSYNC and produces single-cycle edge pulses.
// Ports:
//   clk      : pixel clock
//   rst      : asynchronous active-low reset
//   de_in    : video data enable
//   vs_in    : vertical sync, active-high
//   vs_rise  : high on the first cycle vs_in is high
//   line_end : high on the first blanking cycle after active video
module vid_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic de_in,
  input  logic vs_in,
  output logic vs_rise,
  output logic line_end
);

  logic de_d;
  logic vs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      de_d <= de_in;
      vs_d <= vs_in;
    end
  end

  assign vs_rise  = vs_in & ~vs_d;
  assign line_end = de_d & ~de_in;

endmodule

// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl
// Address sequencer for the vertical line-delay chain (TAPS-1 chained
// single-port BRAMs sharing one address). Follows DE/VSYNC, parks the
// address during blanking, counts buffered lines and flags when the
// TAPS-line window at the chain outputs is valid.
// Optional: define LBC_BORDER_FLAGS_EN to generate the border flags;
// otherwise border is tied to zero.
// Ports:
//   clk       : pixel clock
//   rst       : asynchronous active-low reset
//   de_in     : data enable, same cycle as the pixel entering the chain
//   vs_in     : vertical sync, active-high
//   addr      : shared BRAM address (col_cnt while DE, PARK_ADDR otherwise)
//   win_valid : window valid, one cycle after the sampled pixel
//   fill_lvl  : buffered complete lines, saturates at TAPS-1
//   line_cnt  : completed lines in the current frame
//   col_cnt   : column of the pixel currently addressed
//   ovf       : sticky, a line reached the park address
//   border    : {top,bottom,left,right} window-at-edge flags
//   state     : current sequencer state, for observation
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                TAPS      = TAPS_DEF,
  parameter int                LINE_W    = LINE_W_DEF,
  parameter logic [ADDR_W-1:0] PARK_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] addr,
  output logic              win_valid,
  output logic [2:0]        fill_lvl,
  output logic [LINE_W-1:0] line_cnt,
  output logic [ADDR_W-1:0] col_cnt,
  output logic              ovf,
  output logic [3:0]        border,
  output state_t            state
);

  localparam logic [2:0]        FILL_MAX = 3'(TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = PARK_ADDR - 1'b1;

  logic   vs_rise;
  logic   line_end;
  state_t state_next;
  logic   active;
  logic   at_last_col;

  vid_edge_det u_edge (
    .clk      (clk),
    .rst      (rst),
    .de_in    (de_in),
    .vs_in    (vs_in),
    .vs_rise  (vs_rise),
    .line_end (line_end)
  );

  // DE only has meaning once a frame has started.
  assign active      = (state != IDLE);
  assign at_last_col = (col_cnt == LAST_COL);

  // Combinational so the pixel is written in the cycle it arrives.
  assign addr = (active && de_in) ? col_cnt : PARK_ADDR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (vs_rise) begin
      // A new frame always restarts filling, whatever was in progress.
      state_next = FILL;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        FILL:    if (line_end && fill_lvl >= FILL_MAX - 3'd1) state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt  <= '0;
      line_cnt <= '0;
      fill_lvl <= '0;
    end else if (vs_rise) begin
      col_cnt  <= '0;
      line_cnt <= '0;
      fill_lvl <= '0;
    end else if (active) begin
      if (de_in) begin
        // Hold at the last usable column so the park word stays untouched.
        if (!at_last_col) col_cnt <= col_cnt + 1'b1;
      end else begin
        col_cnt <= '0;
      end
      if (line_end) begin
        line_cnt <= line_cnt + 1'b1;
        if (fill_lvl < FILL_MAX) fill_lvl <= fill_lvl + 3'd1;
      end
    end
  end

  // Sticky until reset; a new frame does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                ovf <= 1'b0;
    else if (active && de_in && at_last_col) ovf <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) win_valid <= 1'b0;
    else      win_valid <= de_in && (state == RUN);
  end

`ifdef LBC_BORDER_FLAGS_EN
  localparam logic [ADDR_W:0] H_COL = (ADDR_W + 1)'(half_taps(TAPS));
  localparam logic [7:0]      H_ROW = 8'(half_taps(TAPS));

  logic [ADDR_W-1:0] last_width;
  logic [7:0]        run_rows;
  logic              top_f;
  logic              left_f;
  logic              right_f;

  // run_rows counts lines since entering RUN, saturating once past the top
  // edge; last_width is the pixel count of the most recent line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_width <= '0;
      run_rows   <= '0;
    end else if (vs_rise) begin
      run_rows <= '0;
    end else if (active && line_end) begin
      last_width <= col_cnt;
      if (state == RUN && run_rows < H_ROW) run_rows <= run_rows + 8'd1;
    end
  end

  assign top_f   = (state == RUN) && (run_rows < H_ROW);
  assign left_f  = ({1'b0, col_cnt} < H_COL);
  // col > last_width-1-HALF, rearranged to avoid underflow.
  assign right_f = (({1'b0, col_cnt} + H_COL) >= {1'b0, last_width});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        border <= 4'b0;
    else if (de_in && state == RUN)  border <= {top_f, 1'b0, left_f, right_f};
    else                             border <= 4'b0;
  end
`else
  assign border = 4'b0;
`endif

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl
// Directed bench for line_buf_ctrl: a default-width instance (ADDR_W=12)
// and a narrow instance (ADDR_W=4) share the same video stimulus.
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. Define LBC_BORDER_FLAGS_EN to expect live border flags.
module tb_line_buf_ctrl;
  import line_buf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic de_in = 1'b0;
  logic vs_in = 1'b0;

  logic [11:0] addr, col_cnt;
  logic        win_valid, ovf;
  logic [2:0]  fill_lvl;
  logic [10:0] line_cnt;
  logic [3:0]  border;
  state_t      state;

  logic [3:0]  addr_s, col_cnt_s;
  logic        win_valid_s, ovf_s;
  logic [2:0]  fill_lvl_s;
  logic [10:0] line_cnt_s;
  logic [3:0]  border_s;
  state_t      state_s;

  int total = 0;
  int bad   = 0;

  localparam logic [11:0] PARK   = 12'hFFF;
  localparam logic [3:0]  PARK_S = 4'hF;
`ifdef LBC_BORDER_FLAGS_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  line_buf_ctrl dut (
    .clk(clk), .rst(rst), .de_in(de_in), .vs_in(vs_in),
    .addr(addr), .win_valid(win_valid), .fill_lvl(fill_lvl),
    .line_cnt(line_cnt), .col_cnt(col_cnt), .ovf(ovf),
    .border(border), .state(state)
  );

  line_buf_ctrl #(.ADDR_W(4)) dut_s (
    .clk(clk), .rst(rst), .de_in(de_in), .vs_in(vs_in),
    .addr(addr_s), .win_valid(win_valid_s), .fill_lvl(fill_lvl_s),
    .line_cnt(line_cnt_s), .col_cnt(col_cnt_s), .ovf(ovf_s),
    .border(border_s), .state(state_s)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver: one pixel-clock cycle with the given DE/VS levels
  task automatic cyc(input logic de, input logic vs);
    @(posedge clk);
    #1;
    de_in = de;
    vs_in = vs;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    total++; if (addr !== PARK) begin bad++; $display("FAIL rst_addr got=%0d exp=%0d", addr, PARK); end
    total++; if (col_cnt !== 12'd0) begin bad++; $display("FAIL rst_col got=%0d exp=0", col_cnt); end
    total++; if (fill_lvl !== 3'd0) begin bad++; $display("FAIL rst_fill got=%0d exp=0", fill_lvl); end
    total++; if (line_cnt !== 11'd0) begin bad++; $display("FAIL rst_line got=%0d exp=0", line_cnt); end
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL rst_win got=%0b exp=0", win_valid); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0b exp=0", ovf); end
    total++; if (border !== 4'b0) begin bad++; $display("FAIL rst_border got=%b exp=0000", border); end
    total++; if (state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", state, IDLE); end
    total++; if (addr_s !== PARK_S) begin bad++; $display("FAIL rst_addr_s got=%0d exp=%0d", addr_s, PARK_S); end
    @(posedge clk); #1 rst = 1'b1;
    // DE without a preceding vsync must be ignored.
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 8; i++) begin
        cyc(1'b1, 1'b0);
        total++; if (addr !== PARK) begin bad++; $display("FAIL idle_addr l=%0d i=%0d got=%0d exp=%0d", l, i, addr, PARK); end
        total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL idle_win l=%0d i=%0d got=%0b exp=0", l, i, win_valid); end
        total++; if (fill_lvl !== 3'd0) begin bad++; $display("FAIL idle_fill l=%0d i=%0d got=%0d exp=0", l, i, fill_lvl); end
      end
      for (int j = 0; j < 4; j++) cyc(1'b0, 1'b0);
    end
  endtask

  task automatic test_fill_run();
    logic   exp_wv;
    state_t exp_st;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    total++; if (state !== FILL) begin bad++; $display("FAIL fill_enter got=%0d exp=%0d", state, FILL); end
    for (int l = 1; l <= 6; l++) begin
      for (int i = 0; i < 8; i++) begin
        cyc(1'b1, 1'b0);
        exp_wv = (i > 0) && (l >= 5);
        total++; if (addr !== 12'(i)) begin bad++; $display("FAIL fill_addr l=%0d i=%0d got=%0d exp=%0d", l, i, addr, i); end
        total++; if (col_cnt !== 12'(i)) begin bad++; $display("FAIL fill_col l=%0d i=%0d got=%0d exp=%0d", l, i, col_cnt, i); end
        total++; if (win_valid !== exp_wv) begin bad++; $display("FAIL fill_win l=%0d i=%0d got=%0b exp=%0b", l, i, win_valid, exp_wv); end
      end
      for (int j = 0; j < 4; j++) begin
        cyc(1'b0, 1'b0);
        exp_wv = (j == 0) && (l >= 5);
        total++; if (addr !== PARK) begin bad++; $display("FAIL blank_addr l=%0d j=%0d got=%0d exp=%0d", l, j, addr, PARK); end
        total++; if (win_valid !== exp_wv) begin bad++; $display("FAIL blank_win l=%0d j=%0d got=%0b exp=%0b", l, j, win_valid, exp_wv); end
        if (j == 1) begin
          exp_st = (l >= 4) ? RUN : FILL;
          total++; if (fill_lvl !== 3'((l < 4) ? l : 4)) begin bad++; $display("FAIL fill_lvl l=%0d got=%0d exp=%0d", l, fill_lvl, (l < 4) ? l : 4); end
          total++; if (line_cnt !== 11'(l)) begin bad++; $display("FAIL line_cnt l=%0d got=%0d exp=%0d", l, line_cnt, l); end
          total++; if (state !== exp_st) begin bad++; $display("FAIL fill_state l=%0d got=%0d exp=%0d", l, state, exp_st); end
          total++; if (col_cnt !== 12'd0) begin bad++; $display("FAIL blank_col l=%0d got=%0d exp=0", l, col_cnt); end
        end
      end
    end
  endtask

  task automatic test_resync();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0);
      total++; if (win_valid !== (i > 0)) begin bad++; $display("FAIL resync_win i=%0d got=%0b exp=%0b", i, win_valid, i > 0); end
    end
    // vsync lands on the line_end cycle
    cyc(1'b0, 1'b1);
    total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL resync_win_last got=%0b exp=1", win_valid); end
    cyc(1'b0, 1'b0);
    total++; if (state !== FILL) begin bad++; $display("FAIL resync_state got=%0d exp=%0d", state, FILL); end
    total++; if (line_cnt !== 11'd0) begin bad++; $display("FAIL resync_line got=%0d exp=0", line_cnt); end
    total++; if (fill_lvl !== 3'd0) begin bad++; $display("FAIL resync_fill got=%0d exp=0", fill_lvl); end
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL resync_win got=%0b exp=0", win_valid); end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    int e;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0);
      e = (i < 14) ? i : 14;
      total++; if (addr_s !== 4'(e)) begin bad++; $display("FAIL ovf_addr i=%0d got=%0d exp=%0d", i, addr_s, e); end
      total++; if (col_cnt_s !== 4'(e)) begin bad++; $display("FAIL ovf_col i=%0d got=%0d exp=%0d", i, col_cnt_s, e); end
      total++; if (ovf_s !== (i >= 15)) begin bad++; $display("FAIL ovf_flag i=%0d got=%0b exp=%0b", i, ovf_s, i >= 15); end
      total++; if (addr !== 12'(i)) begin bad++; $display("FAIL ovf_wide_addr i=%0d got=%0d exp=%0d", i, addr, i); end
    end
    for (int j = 0; j < 4; j++) begin
      cyc(1'b0, 1'b0);
      total++; if (addr_s !== PARK_S) begin bad++; $display("FAIL ovf_park j=%0d got=%0d exp=%0d", j, addr_s, PARK_S); end
    end
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    total++; if (ovf_s !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", ovf_s); end
    total++; if (line_cnt_s !== 11'd0) begin bad++; $display("FAIL ovf_line got=%0d exp=0", line_cnt_s); end
    total++; if (state_s !== FILL) begin bad++; $display("FAIL ovf_state got=%0d exp=%0d", state_s, FILL); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_wide got=%0b exp=0", ovf); end
  endtask

  task automatic test_async_reset();
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
      for (int j = 0; j < 4; j++) cyc(1'b0, 1'b0);
    end
    total++; if (state !== RUN) begin bad++; $display("FAIL areset_pre_state got=%0d exp=%0d", state, RUN); end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    // Pulse reset between clock edges.
    #1 rst = 1'b0;
    #1;
    total++; if (addr !== PARK) begin bad++; $display("FAIL areset_addr got=%0d exp=%0d", addr, PARK); end
    total++; if (col_cnt !== 12'd0) begin bad++; $display("FAIL areset_col got=%0d exp=0", col_cnt); end
    total++; if (fill_lvl !== 3'd0) begin bad++; $display("FAIL areset_fill got=%0d exp=0", fill_lvl); end
    total++; if (line_cnt !== 11'd0) begin bad++; $display("FAIL areset_line got=%0d exp=0", line_cnt); end
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL areset_win got=%0b exp=0", win_valid); end
    total++; if (state !== IDLE) begin bad++; $display("FAIL areset_state got=%0d exp=%0d", state, IDLE); end
    total++; if (ovf_s !== 1'b0) begin bad++; $display("FAIL areset_ovf_s got=%0b exp=0", ovf_s); end
    total++; if (border !== 4'b0) begin bad++; $display("FAIL areset_border got=%b exp=0000", border); end
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      total++; if (addr !== PARK) begin bad++; $display("FAIL areset_idle_addr i=%0d got=%0d exp=%0d", i, addr, PARK); end
    end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0);
      total++; if (addr !== 12'(i)) begin bad++; $display("FAIL restart_addr i=%0d got=%0d exp=%0d", i, addr, i); end
      total++; if (state !== FILL) begin bad++; $display("FAIL restart_state i=%0d got=%0d exp=%0d", i, state, FILL); end
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_border();
    logic [3:0] exp_b;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    for (int l = 1; l <= 7; l++) begin
      for (int i = 0; i < 12; i++) begin
        cyc(i < 8, 1'b0);
        // border reflects the previous cycle's pixel (column i-1)
        exp_b = 4'b0;
        if (BORDER_EN && l >= 5 && i >= 1 && i <= 8)
          exp_b = {l <= 6, 1'b0, (i - 1) < 2, (i - 1) >= 6};
        total++; if (border !== exp_b) begin bad++; $display("FAIL border l=%0d i=%0d got=%b exp=%b", l, i, border, exp_b); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_run();
    test_resync();
    test_overflow();
    test_async_reset();
    test_border();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_buf_ctrl.md
Name: line_buf_ctrl

Overview:
- Sequencer for the 5-tap vertical line-delay chain (four chained single-port BRAMs sharing one address) in the HDMI convolution filter path.
- Derives the shared BRAM address from the incoming video DE/VSYNC, parks the address during blanking, and tracks how many full lines are buffered.
- Flags when the 5-line window is valid for the downstream filter, and reports line/column position plus overflow.

Parameters:
ADDR_W, 12, BRAM address width; matches the line-delay address port.
TAPS, 5, vertical window height; the chain holds TAPS-1 delayed lines.
PARK_ADDR, 2**ADDR_W-1, address driven while DE is low; never used by active video.
LINE_W, 11, width of the line counter.

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-low reset
de_in  in  1  video data enable, same cycle as the pixel entering the delay chain
vs_in  in  1  vertical sync, active-high
addr  out  ADDR_W  shared BRAM address to the delay chain
win_valid  out  1  window valid, aligned to delay-chain outputs (one cycle after the sampled pixel)
fill_lvl  out  3  buffered complete lines, 0..TAPS-1, saturating
line_cnt  out  LINE_W  completed lines in the current frame
col_cnt  out  ADDR_W  column index of the pixel currently addressed
ovf  out  1  sticky: active line reached PARK_ADDR
border  out  4  {top,bottom,left,right} window-at-edge flags (optional feature)

Behaviour:
- Reset (rst=0, async) puts state in IDLE and sets outputs as follows: addr=PARK_ADDR; col_cnt=0, fill_lvl=0, line_cnt=0; win_valid=0, ovf=0, border=0. Asserting rst mid-frame aborts the frame, with no partial state retained.
- Edge detection: registered de_d and vs_d. vs_rise = vs_in & ~vs_d. line_end = de_d & ~de_in.
- FSM states IDLE, FILL and RUN:
  - IDLE: DE ignored and addr parked. On vs_rise go to FILL.
  - FILL: go to RUN on the line_end that brings fill_lvl to TAPS-1.
  - RUN: stays in RUN until the next vs_rise.
  - vs_rise in any state goes to FILL and clears line_cnt, fill_lvl, col_cnt. ovf is not cleared.
- Address generation in FILL/RUN:
  - While de_in=1, addr is a combinational copy of col_cnt, so a pixel is written the same cycle it arrives.
  - col_cnt increments each DE cycle.
  - While de_in=0, addr=PARK_ADDR and col_cnt clears to 0. Blanking writes go only to the park word.
- Overflow: if de_in=1 and col_cnt==PARK_ADDR-1, that pixel is written at PARK_ADDR-1 and col_cnt does not increment. Further pixels reuse PARK_ADDR-1, and ovf is set until reset.
- line_end: line_cnt+1 (wraps at 2**LINE_W); fill_lvl+1, saturating at TAPS-1.
- win_valid: registered (de_in & state==RUN), so it is high the cycle after each sampled pixel. It is 0 throughout FILL.
- Simultaneous vs_rise and line_end: vs_rise wins, and counters clear.

Optional Feature:
- Macro LBC_BORDER_FLAGS_EN. When defined, border is registered alongside win_valid:
  - top: line_cnt < TAPS/2 relative to the first RUN line.
  - bottom: always 0. No frame height is known, so the filter handles the bottom edge at VSYNC.
  - left: col < TAPS/2.
  - right: col > last_width-1-TAPS/2, where last_width is captured at each line_end.
- Without the macro, border is tied to 4'b0 and the width-capture register is absent.

Decomposition:
- Package line_buf_pkg holds:
  - state enum (IDLE/FILL/RUN);
  - TAPS and ADDR_W defaults;
  - derived constant HALF=TAPS/2.
- One natural sub-module, vid_edge_det: DE/VSYNC registering and edge pulses, reusable by other stream blocks.

Test Plan:
- Reset check: reset, then 3 lines of DE with no vsync -> addr stays 4095, win_valid=0, fill_lvl=0.
- Fill to run: vs_rise, then 6 lines of 8 pixels -> during active cycles addr counts 0..7 and parks at 4095 in blanking. fill_lvl steps 1,2,3,4. win_valid goes high on lines 5 and 6 for 8 cycles each, one cycle after DE.
- Re-sync: vs_rise arriving on a line_end cycle in RUN -> next cycle state=FILL, line_cnt=0, fill_lvl=0, win_valid=0.
- Overflow: ADDR_W=4 and a 20-pixel line -> addr saturates at 14, ovf=1 and stays 1 after a later vsync.
- Async reset: rst pulsed low mid-line in RUN -> outputs return to reset values immediately without a clock edge. The bench then waits for vsync before restarting.
- Border flags (with LBC_BORDER_FLAGS_EN), 8-pixel lines -> left=1 at cols 0-1, right=1 at cols 6-7, top=1 on the first 2 RUN lines.
